// File: rtl/thread_scheduler.sv
// Issue-slot scheduler for the barrel core: rotates a slot counter across all threads and
// tracks the active and restart-pending thread sets through IDLE, RUN and DRAIN.
module thread_scheduler #(
  parameter int                      NUM_THREADS = 16,
  parameter int                      TID_WIDTH   = $clog2(NUM_THREADS),
  parameter int                      PIPE_DEPTH  = 16,
  parameter logic [NUM_THREADS-1:0]  BOOT_MASK   = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   halt_req_i,
  input  logic [TID_WIDTH-1:0]   halt_tid_i,
  input  logic                   wake_req_i,
  input  logic [NUM_THREADS-1:0] wake_mask_i,
  output logic                   issue_valid_o,
  output logic [TID_WIDTH-1:0]   issue_tid_o,
  output logic                   issue_restart_o,
  output logic [NUM_THREADS-1:0] active_mask_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [TID_WIDTH-1:0]   slot_q;
  logic [NUM_THREADS-1:0] active_q;
  logic [NUM_THREADS-1:0] restart_q;
  logic [CW-1:0]          drain_q;
  logic                   done_q;

  logic [NUM_THREADS-1:0] wake_vec;
  logic [NUM_THREADS-1:0] halt_vec;
  logic [NUM_THREADS-1:0] clr_vec;
  logic [NUM_THREADS-1:0] active_run;
  logic [NUM_THREADS-1:0] restart_run;
  logic                   issue_now;

  // Wake beats halt on the same thread, so halt only touches threads not being woken.
  always_comb begin
    wake_vec    = wake_req_i ? wake_mask_i : '0;
    halt_vec    = halt_req_i ? (NUM_THREADS'(1) << halt_tid_i) : '0;
    halt_vec    = halt_vec & ~wake_vec;
    issue_now   = (state_q == RUN) && active_q[slot_q];
    clr_vec     = (issue_now && restart_q[slot_q]) ? (NUM_THREADS'(1) << slot_q) : '0;
    active_run  = (active_q & ~halt_vec) | wake_vec;
    restart_run = (restart_q & ~halt_vec & ~clr_vec) | (wake_vec & ~active_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i || (|wake_vec)) state_d = RUN;
      RUN:     if (active_run == '0)       state_d = DRAIN;
      DRAIN:   if (|wake_vec)              state_d = RUN;
               else if (drain_q == '0)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= '0;
      active_q  <= '0;
      restart_q <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && (state_d == IDLE);
      case (state_q)
        IDLE: begin
          slot_q  <= '0;
          drain_q <= '0;
          if (start_i) begin
            active_q  <= BOOT_MASK | wake_vec;
            restart_q <= BOOT_MASK | wake_vec;
          end else if (|wake_vec) begin
            active_q  <= wake_vec;
            restart_q <= wake_vec;
          end
        end
        RUN: begin
          // Strict rotation: inactive slots are never skipped.
          slot_q    <= slot_q + TID_WIDTH'(1);
          active_q  <= active_run;
          restart_q <= restart_run;
          if (active_run == '0) drain_q <= CW'(PIPE_DEPTH - 1);
        end
        DRAIN: begin
          if (|wake_vec) begin
            slot_q    <= slot_q + TID_WIDTH'(1);
            active_q  <= wake_vec;
            restart_q <= wake_vec;
          end else if (drain_q == '0) begin
            slot_q <= '0;
          end else begin
            slot_q  <= slot_q + TID_WIDTH'(1);
            drain_q <= drain_q - CW'(1);
          end
        end
        default: begin
          slot_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    issue_valid_o   = issue_now;
    issue_tid_o     = slot_q;
    issue_restart_o = issue_now && restart_q[slot_q];
    active_mask_o   = active_q;
    busy_o          = (state_q != IDLE);
    done_o          = done_q;
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: boot, wake rotation, halt/wake collision, drain,
// wake during drain and asynchronous reset mid-run.
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic        halt_req_i;
  logic [3:0]  halt_tid_i;
  logic        wake_req_i;
  logic [15:0] wake_mask_i;
  logic        issue_valid_o;
  logic [3:0]  issue_tid_o;
  logic        issue_restart_o;
  logic [15:0] active_mask_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  thread_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_i         (start_i),
    .halt_req_i      (halt_req_i),
    .halt_tid_i      (halt_tid_i),
    .wake_req_i      (wake_req_i),
    .wake_mask_i     (wake_mask_i),
    .issue_valid_o   (issue_valid_o),
    .issue_tid_o     (issue_tid_o),
    .issue_restart_o (issue_restart_o),
    .active_mask_o   (active_mask_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},   32'(issue_valid_o),   0);
    chk({tag, ".tid"},     32'(issue_tid_o),     0);
    chk({tag, ".restart"}, 32'(issue_restart_o), 0);
    chk({tag, ".active"},  32'(active_mask_o),   0);
    chk({tag, ".busy"},    32'(busy_o),          0);
    chk({tag, ".done"},    32'(done_o),          0);
  endtask

  // RUN cycles starting at slot 'base'; restart expected only within the first rotation.
  task automatic run_cycles(input string tag, input int base, input int n,
                            input logic [15:0] vm, input logic [15:0] rm);
    for (int k = 0; k < n; k++) begin
      int s;
      s = (base + k) % 16;
      chk({tag, ".tid"},     32'(issue_tid_o),     32'(s));
      chk({tag, ".valid"},   32'(issue_valid_o),   32'(vm[s]));
      chk({tag, ".restart"}, 32'(issue_restart_o), (k < 16) ? 32'(rm[s]) : 0);
      chk({tag, ".busy"},    32'(busy_o),          1);
      chk({tag, ".done"},    32'(done_o),          0);
      tick();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start_i     = 1'b0;
    halt_req_i  = 1'b0;
    halt_tid_i  = '0;
    wake_req_i  = 1'b0;
    wake_mask_i = '0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_idle("idle");

    // Boot: only thread 0 issues, restart on its first issue only.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("boot.active", 32'(active_mask_o), 32'h0001);
    run_cycles("boot", 0, 32, 16'h0001, 16'h0001);

    // Start in RUN is ignored: no new restart for thread 0.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_cycles("start_ign", 1, 15, 16'h0001, 16'h0000);

    // Wake 0x8005 at slot 0.
    wake_req_i  = 1'b1;
    wake_mask_i = 16'h8005;
    tick();
    wake_req_i  = 1'b0;
    chk("wake.active", 32'(active_mask_o), 32'h8005);
    run_cycles("wake", 1, 31, 16'h8005, 16'h8004);

    // Collision with thread 2 active: stays active, no restart.
    halt_req_i  = 1'b1;
    halt_tid_i  = 4'd2;
    wake_req_i  = 1'b1;
    wake_mask_i = 16'h0004;
    tick();
    halt_req_i  = 1'b0;
    wake_req_i  = 1'b0;
    chk("coll_act.active", 32'(active_mask_o), 32'h8005);
    run_cycles("coll_act", 1, 15, 16'h8005, 16'h0000);

    // Halt thread 2, then collide while it is inactive: restart once.
    halt_req_i = 1'b1;
    halt_tid_i = 4'd2;
    tick();
    halt_req_i = 1'b0;
    chk("halt2.active", 32'(active_mask_o), 32'h8001);
    halt_req_i  = 1'b1;
    wake_req_i  = 1'b1;
    wake_mask_i = 16'h0004;
    tick();
    halt_req_i  = 1'b0;
    wake_req_i  = 1'b0;
    chk("coll_inact.active", 32'(active_mask_o), 32'h8005);
    run_cycles("coll_inact", 2, 30, 16'h8005, 16'h0004);

    // Drain: halt 0 (still issues this cycle), then 2, then 15.
    chk("drain.issue_on_halt", 32'(issue_valid_o), 1);
    halt_req_i = 1'b1;
    halt_tid_i = 4'd0;
    tick();
    halt_tid_i = 4'd2;
    tick();
    chk("drain.halted2_valid", 32'(issue_valid_o), 0);
    chk("drain.active_8000",   32'(active_mask_o), 32'h8000);
    halt_tid_i = 4'd15;
    tick();
    halt_req_i = 1'b0;
    chk("drain.active_0", 32'(active_mask_o), 0);
    for (int j = 0; j < 16; j++) begin
      chk("drain.tid",   32'(issue_tid_o),   32'((3 + j) % 16));
      chk("drain.valid", 32'(issue_valid_o), 0);
      chk("drain.busy",  32'(busy_o),        1);
      chk("drain.done",  32'(done_o),        0);
      tick();
    end
    chk("drain.done_pulse", 32'(done_o),        1);
    chk("drain.busy_off",   32'(busy_o),        0);
    chk("drain.tid0",       32'(issue_tid_o),   0);
    chk("drain.valid_off",  32'(issue_valid_o), 0);
    tick();
    chk("drain.done_once", 32'(done_o), 0);

    // Wake during drain on the 5th DRAIN cycle.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("wd.boot_restart", 32'(issue_restart_o), 1);
    halt_req_i = 1'b1;
    halt_tid_i = 4'd0;
    tick();
    halt_req_i = 1'b0;
    for (int j = 1; j < 5; j++) begin
      chk("wd.tid",   32'(issue_tid_o),   32'(j));
      chk("wd.valid", 32'(issue_valid_o), 0);
      tick();
    end
    chk("wd.tid5", 32'(issue_tid_o), 5);
    chk("wd.busy", 32'(busy_o),      1);
    wake_req_i  = 1'b1;
    wake_mask_i = 16'h0010;
    tick();
    wake_req_i  = 1'b0;
    chk("wd.active", 32'(active_mask_o), 32'h0010);
    run_cycles("wd", 6, 15, 16'h0010, 16'h0010);

    // Async reset between edges while in RUN.
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("areset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_idle("post_reset");
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("resume.valid",   32'(issue_valid_o),   1);
    chk("resume.restart", 32'(issue_restart_o), 1);
    chk("resume.tid",     32'(issue_tid_o),     0);
    chk("resume.active",  32'(active_mask_o),   32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
